// File: rtl/imem_fetch.sv
// imem_fetch: clocked instruction memory with a valid/ready fetch port.
// - DEPTH x DATA_W array, loaded through a write port (ld_*).
// - Registered response stage with one-cycle latency, backpressure, flush, and out-of-range flag.
// - Optional accepted-fetch counter, built only when IMEM_FETCH_CNT_EN is defined;
//   otherwise fetch_cnt is tied to zero.
module imem_fetch #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_adr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [15:0]       fetch_cnt
);

  // Array index width; the full address is still used for the range compare.
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH > (2 ** ADDR_W)) begin : g_depth_check
    $error("imem_fetch: DEPTH exceeds the address space");
  end

  typedef enum logic {
    StEmpty,
    StFull
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  // Power-up content is NOP_WORD; reset deliberately leaves the array alone.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

  logic            accept;
  logic            req_in_range;
  logic            ld_in_range;
  logic [IdxW-1:0] req_idx;
  logic [IdxW-1:0] ld_idx;

  // Unsigned range checks on the full address, so nothing wraps modulo DEPTH.
  assign req_in_range = 32'(req_adr) < DEPTH;
  assign ld_in_range  = 32'(ld_adr) < DEPTH;
  assign req_idx      = req_adr[IdxW-1:0];
  assign ld_idx       = ld_adr[IdxW-1:0];

  // Handshake: a held response blocks new requests unless it drains or is flushed.
  always_comb begin
    req_ready = rst & ~ld_en & ((state_q == StEmpty) | rsp_ready | flush);
    accept    = req_valid & req_ready;
    rsp_valid = (state_q == StFull);
  end

  // Output stage next state: accept wins, otherwise flush or consume empties the stage.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      state_d = StFull;
      if (req_in_range) begin
        rsp_data_d = mem_q[req_idx];
        rsp_err_d  = 1'b0;
      end else begin
        rsp_data_d = NOP_WORD;
        rsp_err_d  = 1'b1;
      end
    end else if (state_q == StFull && (flush || rsp_ready)) begin
      state_d = StEmpty;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      rsp_data_q <= NOP_WORD;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Program-load write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) begin
      mem_q[ld_idx] <= ld_data;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

`ifdef IMEM_FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of accepted fetches, including out-of-range ones.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt = cnt_q;
`else
  assign fetch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch (DEPTH=24 so out-of-range addresses exist).
module tb_imem_fetch;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 24;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_adr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              flush;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_adr;
  logic [DATA_W-1:0] ld_data;
  logic [15:0]       fetch_cnt;

  int checks;
  int failures;
  int exp_cnt;

  imem_fetch #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .NOP_WORD(16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_adr  (req_adr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_adr   (ld_adr),
    .ld_data  (ld_data),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef IMEM_FETCH_CNT_EN
    chk(tag, 32'(fetch_cnt), 32'(exp_cnt));
`else
    chk(tag, 32'(fetch_cnt), 32'd0);
`endif
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_cnt   = 0;
    rst       = 1'b0;
    req_valid = 1'b1;
    req_adr   = 5'd3;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    ld_en     = 1'b0;
    ld_adr    = '0;
    ld_data   = '0;

    // Reset held for 3 cycles with a request pending.
    repeat (3) tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0000);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk_cnt("rst_cnt");

    // Default read of adr 3 returns NOP.
    rst = 1'b1;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    tick(); exp_cnt++;
    req_valid = 1'b0;
    chk("dflt_valid", 32'(rsp_valid), 32'd1);
    chk("dflt_data", 32'(rsp_data), 32'h0000);
    chk("dflt_err", 32'(rsp_err), 32'd0);
    tick();
    chk("dflt_drain", 32'(rsp_valid), 32'd0);

    // Load then fetch; the load cycle blocks the request.
    ld_en = 1'b1; ld_adr = 5'd0; ld_data = 16'hE201;
    req_valid = 1'b1; req_adr = 5'd0;
    #1;
    chk("ld_req_ready", 32'(req_ready), 32'd0);
    tick();
    ld_en = 1'b0;
    chk("ld_no_accept", 32'(rsp_valid), 32'd0);
    tick(); exp_cnt++;
    req_valid = 1'b0;
    chk("ld_fetch_data", 32'(rsp_data), 32'hE201);
    chk("ld_fetch_valid", 32'(rsp_valid), 32'd1);
    chk_cnt("ld_cnt");
    tick();

    // Load 1..4 and 10.
    for (int i = 1; i <= 4; i++) begin
      ld_en = 1'b1; ld_adr = 5'(i); ld_data = 16'(i * 16'h1111);
      tick();
    end
    ld_adr = 5'd10; ld_data = 16'hABCD;
    tick();
    ld_en = 1'b0;

    // Streaming with 2 stall cycles after the first response.
    req_valid = 1'b1; req_adr = 5'd1; rsp_ready = 1'b1;
    tick(); exp_cnt++;
    rsp_ready = 1'b0; req_adr = 5'd2;
    #1;
    chk("bp_data0", 32'(rsp_data), 32'h1111);
    chk("bp_ready0", 32'(req_ready), 32'd0);
    tick();
    chk("bp_data1", 32'(rsp_data), 32'h1111);
    chk("bp_valid1", 32'(rsp_valid), 32'd1);
    chk("bp_ready1", 32'(req_ready), 32'd0);
    tick();
    chk("bp_data2", 32'(rsp_data), 32'h1111);
    rsp_ready = 1'b1;
    tick(); exp_cnt++;
    req_adr = 5'd3;
    chk("st_data2", 32'(rsp_data), 32'h2222);
    tick(); exp_cnt++;
    req_adr = 5'd4;
    chk("st_data3", 32'(rsp_data), 32'h3333);
    tick(); exp_cnt++;
    req_valid = 1'b0;
    chk("st_data4", 32'(rsp_data), 32'h4444);
    chk("st_valid4", 32'(rsp_valid), 32'd1);
    chk_cnt("st_cnt");
    tick();
    chk("st_drain", 32'(rsp_valid), 32'd0);

    // Flush with a simultaneous request replaces the held adr-2 word.
    req_valid = 1'b1; req_adr = 5'd2;
    tick(); exp_cnt++;
    req_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    chk("fl_hold", 32'(rsp_data), 32'h2222);
    flush = 1'b1; req_valid = 1'b1; req_adr = 5'd10;
    #1;
    chk("fl_req_ready", 32'(req_ready), 32'd1);
    tick(); exp_cnt++;
    flush = 1'b0; req_valid = 1'b0;
    chk("fl_valid", 32'(rsp_valid), 32'd1);
    chk("fl_data", 32'(rsp_data), 32'hABCD);
    // Flush alone drops the held response despite rsp_ready=0.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_drop", 32'(rsp_valid), 32'd0);

    // Out-of-range load and fetches.
    ld_en = 1'b1; ld_adr = 5'd30; ld_data = 16'hBEEF;
    tick();
    ld_en = 1'b0;
    rsp_ready = 1'b1; req_valid = 1'b1; req_adr = 5'd30;
    tick(); exp_cnt++;
    req_adr = 5'd24;
    chk("oor30_data", 32'(rsp_data), 32'h0000);
    chk("oor30_err", 32'(rsp_err), 32'd1);
    chk("oor30_valid", 32'(rsp_valid), 32'd1);
    tick(); exp_cnt++;
    req_adr = 5'd6;
    chk("oor24_err", 32'(rsp_err), 32'd1);
    tick(); exp_cnt++;
    req_adr = 5'd23;
    chk("wrap6_data", 32'(rsp_data), 32'h0000);
    chk("wrap6_err", 32'(rsp_err), 32'd0);
    tick(); exp_cnt++;
    req_adr = 5'd1;
    chk("in23_err", 32'(rsp_err), 32'd0);
    tick(); exp_cnt++;
    req_valid = 1'b0;
    chk("in1_data", 32'(rsp_data), 32'h1111);
    chk_cnt("oor_cnt");
    tick();

    // Reset in mid-stream with a response held.
    req_valid = 1'b1; req_adr = 5'd4; rsp_ready = 1'b0;
    tick(); exp_cnt++;
    chk_cnt("pre_rst_cnt");
    rst = 1'b0; exp_cnt = 0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 32'd0);
    chk("mr_data", 32'(rsp_data), 32'h0000);
    chk("mr_err", 32'(rsp_err), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk_cnt("mr_cnt");
    tick();
    rst = 1'b1; rsp_ready = 1'b1;
    tick(); exp_cnt++;
    req_valid = 1'b0;
    chk("mr_keep_data", 32'(rsp_data), 32'h4444);
    chk_cnt("post_rst_cnt");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
